approx_mult_error_monitor: RTL and testbench

//   Synthesizable error-metric engine for approximate multipliers. It takes operand pairs
//   and the approximate product from a multiplier under test, and computes the exact

---
 rtl/approx_mult_error_monitor.sv | 275 +++++++++++++++++++++++++++
 tb/tb_approx_mult_error_monitor.sv | 326 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/approx_mult_error_monitor.sv
// approx_mult_error_monitor
//   Error-metric engine for an approximate multiplier under test. Each accepted
//   sample is multiplied exactly and compared against the approximate product.
//   Over a window of 2**LOG2_SAMPLES samples it accumulates the error count, the
//   signed and absolute error-distance sums, the maximum error distance together
//   with the operands that first produced it, and the mean absolute error (MED).
//   Datapath: S1 captures operands and the exact product, S2 forms the signed and
//   absolute difference, and S3 folds the difference into the accumulators.
module approx_mult_error_monitor #(
  parameter int WIDTH        = 8,
  parameter int LOG2_SAMPLES = 14
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_a,
  input  logic [WIDTH-1:0]                in_b,
  input  logic [2*WIDTH-1:0]              in_apprx,
  output logic                            busy,
  output logic                            done,
  output logic [LOG2_SAMPLES:0]           sample_cnt,
  output logic [LOG2_SAMPLES:0]           err_cnt,
  output logic [2*WIDTH+LOG2_SAMPLES-1:0] sum_abs_ed,
  output logic [2*WIDTH+LOG2_SAMPLES:0]   sum_ed,
  output logic [2*WIDTH-1:0]              max_ed,
  output logic [WIDTH-1:0]                max_a,
  output logic [WIDTH-1:0]                max_b,
  output logic [2*WIDTH-1:0]              med
);

  // Derived widths: product, signed difference, counters and both sums.
  localparam int PW  = 2 * WIDTH;
  localparam int DW  = PW + 1;
  localparam int CW  = LOG2_SAMPLES + 1;
  localparam int SAW = PW + LOG2_SAMPLES;
  localparam int SEW = PW + LOG2_SAMPLES + 1;

  localparam logic [CW-1:0] CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] N_SAMPLES = CNT_ONE << LOG2_SAMPLES;
  localparam logic [CW-1:0] LAST_IDX  = N_SAMPLES - CNT_ONE;

  // Controller states.
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // ---------------------------------------------------------------------------
  // Control state
  // ---------------------------------------------------------------------------
  logic [1:0] state_q, state_d;
  logic       drain_cnt_q, drain_cnt_d;

  logic accept;       // sample handshake this cycle
  logic start_clr;    // start accepted: clears results on the same edge that enters RUN
  logic last_sample;  // the sample being accepted is the N-th of the window
  logic drain_exit;   // final DRAIN cycle; results are complete at the next edge

  assign in_ready    = (state_q == ST_RUN);
  assign busy        = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done        = (state_q == ST_DONE);
  assign accept      = in_valid && in_ready;
  assign start_clr   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign drain_exit  = (state_q == ST_DRAIN) && drain_cnt_q;

  // ---------------------------------------------------------------------------
  // S1: operands, approximate product and exact product
  // ---------------------------------------------------------------------------
  logic             v1_q, v1_d;
  logic [WIDTH-1:0] a1_q, a1_d;
  logic [WIDTH-1:0] b1_q, b1_d;
  logic [PW-1:0]    apprx1_q, apprx1_d;
  logic [PW-1:0]    exact1_q, exact1_d;
  logic [PW-1:0]    exact_c;

  // Zero-extend both operands so the multiply is evaluated at full product width.
  assign exact_c = {{WIDTH{1'b0}}, in_a} * {{WIDTH{1'b0}}, in_b};

  // ---------------------------------------------------------------------------
  // S2: signed difference and its magnitude, operands carried for max tracking
  // ---------------------------------------------------------------------------
  logic             v2_q, v2_d;
  logic [WIDTH-1:0] a2_q, a2_d;
  logic [WIDTH-1:0] b2_q, b2_d;
  logic [DW-1:0]    d2_q, d2_d;
  logic [PW-1:0]    absd2_q, absd2_d;

  // ---------------------------------------------------------------------------
  // S3: accumulators and results
  // ---------------------------------------------------------------------------
  logic [CW-1:0]    sample_cnt_q, sample_cnt_d;
  logic [CW-1:0]    err_cnt_q, err_cnt_d;
  logic [SAW-1:0]   sum_abs_q, sum_abs_d;
  logic [SEW-1:0]   sum_ed_q, sum_ed_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [WIDTH-1:0] max_a_q, max_a_d;
  logic [WIDTH-1:0] max_b_q, max_b_d;
  logic [PW-1:0]    med_q, med_d;

  assign last_sample = (sample_cnt_q == LAST_IDX);

  // Next-state logic: RUN until the N-th acceptance, then two DRAIN cycles to flush S2/S3.
  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && last_sample) begin
          state_d     = ST_DRAIN;
          drain_cnt_d = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt_q) state_d = ST_DONE;
        else             drain_cnt_d = 1'b1;
      end
      ST_DONE: begin
        if (start) state_d = ST_RUN;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // S1 next values: capture only on acceptance so idle cycles leave the stage untouched.
  always_comb begin
    v1_d     = accept;
    a1_d     = a1_q;
    b1_d     = b1_q;
    apprx1_d = apprx1_q;
    exact1_d = exact1_q;
    if (accept) begin
      a1_d     = in_a;
      b1_d     = in_b;
      apprx1_d = in_apprx;
      exact1_d = exact_c;
    end
  end

  // S2 next values: one extra bit keeps exact-apprx exact; magnitude avoids a negate of d.
  always_comb begin
    v2_d    = v1_q;
    a2_d    = a2_q;
    b2_d    = b2_q;
    d2_d    = d2_q;
    absd2_d = absd2_q;
    if (v1_q) begin
      a2_d = a1_q;
      b2_d = b1_q;
      d2_d = {1'b0, exact1_q} - {1'b0, apprx1_q};
      if (exact1_q >= apprx1_q) absd2_d = exact1_q - apprx1_q;
      else                      absd2_d = apprx1_q - exact1_q;
    end
  end

  // S3 next values: clear on start, count acceptances, fold in S2 results, latch MED at the end.
  always_comb begin
    sample_cnt_d = sample_cnt_q;
    err_cnt_d    = err_cnt_q;
    sum_abs_d    = sum_abs_q;
    sum_ed_d     = sum_ed_q;
    max_ed_d     = max_ed_q;
    max_a_d      = max_a_q;
    max_b_d      = max_b_q;
    med_d        = med_q;
    if (start_clr) begin
      sample_cnt_d = '0;
      err_cnt_d    = '0;
      sum_abs_d    = '0;
      sum_ed_d     = '0;
      max_ed_d     = '0;
      max_a_d      = '0;
      max_b_d      = '0;
      med_d        = '0;
    end else begin
      if (accept) begin
        sample_cnt_d = sample_cnt_q + CNT_ONE;
      end
      if (v2_q) begin
        if (absd2_q != '0) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end
        sum_abs_d = sum_abs_q + {{LOG2_SAMPLES{1'b0}}, absd2_q};
        sum_ed_d  = sum_ed_q + {{(SEW-DW){d2_q[DW-1]}}, d2_q};
        // Strict compare: on a tie the earlier sample keeps its operands.
        if (absd2_q > max_ed_q) begin
          max_ed_d = absd2_q;
          max_a_d  = a2_q;
          max_b_d  = b2_q;
        end
      end
      // The last sample reaches S3 on this same edge, so MED uses the updated sum.
      if (drain_exit) begin
        med_d = sum_abs_d[SAW-1:LOG2_SAMPLES];
      end
    end
  end

  // Control registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      drain_cnt_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
    end
  end

  // Pipeline registers; reset discards any in-flight samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q     <= 1'b0;
      a1_q     <= '0;
      b1_q     <= '0;
      apprx1_q <= '0;
      exact1_q <= '0;
      v2_q     <= 1'b0;
      a2_q     <= '0;
      b2_q     <= '0;
      d2_q     <= '0;
      absd2_q  <= '0;
    end else begin
      v1_q     <= v1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      apprx1_q <= apprx1_d;
      exact1_q <= exact1_d;
      v2_q     <= v2_d;
      a2_q     <= a2_d;
      b2_q     <= b2_d;
      d2_q     <= d2_d;
      absd2_q  <= absd2_d;
    end
  end

  // Accumulator and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt_q <= '0;
      err_cnt_q    <= '0;
      sum_abs_q    <= '0;
      sum_ed_q     <= '0;
      max_ed_q     <= '0;
      max_a_q      <= '0;
      max_b_q      <= '0;
      med_q        <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      err_cnt_q    <= err_cnt_d;
      sum_abs_q    <= sum_abs_d;
      sum_ed_q     <= sum_ed_d;
      max_ed_q     <= max_ed_d;
      max_a_q      <= max_a_d;
      max_b_q      <= max_b_d;
      med_q        <= med_d;
    end
  end

  assign sample_cnt = sample_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign sum_abs_ed = sum_abs_q;
  assign sum_ed     = sum_ed_q;
  assign max_ed     = max_ed_q;
  assign max_a      = max_a_q;
  assign max_b      = max_b_q;
  assign med        = med_q;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Testbench for approx_mult_error_monitor with WIDTH=8, LOG2_SAMPLES=2 (N=4).
module tb_approx_mult_error_monitor;

  localparam int W = 8;
  localparam int L = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [W-1:0]      in_a = '0;
  logic [W-1:0]      in_b = '0;
  logic [2*W-1:0]    in_apprx = '0;
  logic              busy;
  logic              done;
  logic [L:0]        sample_cnt;
  logic [L:0]        err_cnt;
  logic [2*W+L-1:0]  sum_abs_ed;
  logic [2*W+L:0]    sum_ed;
  logic [2*W-1:0]    max_ed;
  logic [W-1:0]      max_a;
  logic [W-1:0]      max_b;
  logic [2*W-1:0]    med;

  approx_mult_error_monitor #(.WIDTH(W), .LOG2_SAMPLES(L)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_apprx   (in_apprx),
    .busy       (busy),
    .done       (done),
    .sample_cnt (sample_cnt),
    .err_cnt    (err_cnt),
    .sum_abs_ed (sum_abs_ed),
    .sum_ed     (sum_ed),
    .max_ed     (max_ed),
    .max_a      (max_a),
    .max_b      (max_b),
    .med        (med)
  );

  always #5 clk = ~clk;

  typedef struct {
    int err;
    int sabs;
    int sed;
    int maxed;
    int ma;
    int mb;
    int med;
  } exp_t;

  typedef struct {
    string            name;
    bit [3:0][7:0]    a;
    bit [3:0][7:0]    b;
    bit [3:0][15:0]   p;
    exp_t             e;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference: plain arithmetic over the window's samples.
  function automatic exp_t model(input bit [3:0][7:0] a, input bit [3:0][7:0] b,
                                 input bit [3:0][15:0] p);
    exp_t r;
    r = '{default: 0};
    for (int i = 0; i < 4; i++) begin
      int ex, d, ad;
      ex = int'(a[i]) * int'(b[i]);
      d  = ex - int'(p[i]);
      ad = (d < 0) ? -d : d;
      if (ad != 0) r.err++;
      r.sabs += ad;
      r.sed  += d;
      if (ad > r.maxed) begin
        r.maxed = ad;
        r.ma    = int'(a[i]);
        r.mb    = int'(b[i]);
      end
    end
    r.med = r.sabs / 4;
    return r;
  endfunction

  function automatic vec_t mk(input string n,
                              input int a0, input int b0, input int p0,
                              input int a1, input int b1, input int p1,
                              input int a2, input int b2, input int p2,
                              input int a3, input int b3, input int p3,
                              input int err, input int sabs, input int sed,
                              input int mx, input int ma, input int mb, input int md);
    vec_t v;
    v.name = n;
    v.a[0] = 8'(a0);  v.b[0] = 8'(b0);  v.p[0] = 16'(p0);
    v.a[1] = 8'(a1);  v.b[1] = 8'(b1);  v.p[1] = 16'(p1);
    v.a[2] = 8'(a2);  v.b[2] = 8'(b2);  v.p[2] = 16'(p2);
    v.a[3] = 8'(a3);  v.b[3] = 8'(b3);  v.p[3] = 16'(p3);
    v.e = '{err: err, sabs: sabs, sed: sed, maxed: mx, ma: ma, mb: mb, med: md};
    return v;
  endfunction

  // Pulse start for one cycle; on return the start edge has passed and results must read 0.
  task automatic pulse_start(input string tag);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({tag, ".clr_cnt"}, longint'(sample_cnt), 0);
    check({tag, ".clr_sabs"}, longint'(sum_abs_ed), 0);
    check({tag, ".clr_max"}, longint'(max_ed), 0);
    check({tag, ".clr_med"}, longint'(med), 0);
    check({tag, ".run_ready"}, longint'(in_ready), 1);
  endtask

  // Present samples 0..n-1, optionally with idle gaps carrying junk data.
  task automatic feed(input bit [3:0][7:0] a, input bit [3:0][7:0] b,
                      input bit [3:0][15:0] p, input bit gaps, input int n,
                      input string tag);
    int idx = 0;
    int budget = 0;
    while (idx < n && budget < 200) begin
      @(negedge clk);
      budget++;
      if (gaps && ($urandom_range(0, 3) == 0)) begin
        in_valid = 1'b0;
        in_a     = 8'($urandom);
        in_b     = 8'($urandom);
        in_apprx = 16'($urandom);
      end else begin
        in_valid = 1'b1;
        in_a     = a[idx];
        in_b     = b[idx];
        in_apprx = p[idx];
        if (in_ready) idx++;
      end
    end
    if (idx < n) check({tag, ".feed_timeout"}, idx, n);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called right after the last acceptance: expects DRAIN now and DONE after exactly 2 cycles.
  task automatic wait_done(input string tag);
    int budget = 0;
    check({tag, ".drain_ready"}, longint'(in_ready), 0);
    check({tag, ".drain_busy"}, longint'(busy), 1);
    check({tag, ".drain_med"}, longint'(med), 0);
    while (!done && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    check({tag, ".drain_len"}, budget, 2);
  endtask

  task automatic check_res(input string tag, input exp_t e);
    check({tag, ".done"}, longint'(done), 1);
    check({tag, ".cnt"}, longint'(sample_cnt), 4);
    check({tag, ".err"}, longint'(err_cnt), e.err);
    check({tag, ".sabs"}, longint'(sum_abs_ed), e.sabs);
    check({tag, ".sed"}, longint'($signed(sum_ed)), e.sed);
    check({tag, ".max"}, longint'(max_ed), e.maxed);
    check({tag, ".max_a"}, longint'(max_a), e.ma);
    check({tag, ".max_b"}, longint'(max_b), e.mb);
    check({tag, ".med"}, longint'(med), e.med);
  endtask

  vec_t tbl[5];

  initial begin
    bit [3:0][7:0]  ra, rb;
    bit [3:0][15:0] rp;
    exp_t           ex;
    int             cnt;
    bit             pulsed;

    // Hand-derived windows.
    tbl[0] = mk("exact", 3,5,15, 255,255,65025, 0,7,0, 16,16,256,
                0, 0, 0, 0, 0, 0, 0);
    tbl[1] = mk("mixed", 10,10,96, 20,20,410, 255,255,65000, 1,1,1,
                3, 39, 19, 25, 255, 255, 9);
    tbl[2] = mk("ties", 3,4,5, 2,2,4, 5,6,23, 1,1,1,
                2, 14, 14, 7, 3, 4, 3);
    tbl[3] = mk("worst", 255,255,0, 255,255,0, 255,255,0, 255,255,0,
                4, 260100, 260100, 65025, 255, 255, 65025);
    tbl[4] = mk("negative", 0,5,65535, 1,1,0, 2,3,65535, 0,0,0,
                3, 131065, -131063, 65535, 0, 5, 32766);

    // Reset state.
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst.ready", longint'(in_ready), 0);
    check("rst.busy", longint'(busy), 0);
    check("rst.done", longint'(done), 0);
    check("rst.cnt", longint'(sample_cnt), 0);
    check("rst.sed", longint'(sum_ed), 0);
    check("rst.max_ab", longint'({max_a, max_b}), 0);

    // Reset mid-RUN after 2 samples aborts the window and drops in-flight samples.
    ra = '{default: 8'd9};
    rb = '{default: 8'd9};
    rp = '{default: 16'd0};
    pulse_start("abort");
    feed(ra, rb, rp, 1'b0, 2, "abort");
    check("abort.mid_cnt", longint'(sample_cnt), 2);
    rst = 1'b1;
    @(negedge clk);
    check("abort.ready", longint'(in_ready), 0);
    check("abort.busy", longint'(busy), 0);
    check("abort.cnt", longint'(sample_cnt), 0);
    check("abort.sabs", longint'(sum_abs_ed), 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort.idle_ready", longint'(in_ready), 0);
    check("abort.flushed_sabs", longint'(sum_abs_ed), 0);
    check("abort.flushed_err", longint'(err_cnt), 0);

    // Table-driven windows; each start comes from IDLE or DONE of the previous window.
    for (int i = 0; i < 5; i++) begin
      pulse_start(tbl[i].name);
      feed(tbl[i].a, tbl[i].b, tbl[i].p, i[0], 4, tbl[i].name);
      wait_done(tbl[i].name);
      check_res(tbl[i].name, tbl[i].e);
      $display("window %s: err=%0d sabs=%0d sed=%0d max=%0d med=%0d", tbl[i].name,
               err_cnt, sum_abs_ed, $signed(sum_ed), max_ed, med);
    end

    // Latency: a sample shows up in the accumulators on the third cycle after acceptance.
    pulse_start("lat");
    @(negedge clk);
    in_valid = 1'b1;  in_a = 8'd7;  in_b = 8'd7;  in_apprx = 16'd44;
    @(negedge clk);
    in_valid = 1'b0;
    check("lat.cnt1", longint'(sample_cnt), 1);
    check("lat.c1", longint'(sum_abs_ed), 0);
    @(negedge clk);
    check("lat.c2", longint'(sum_abs_ed), 0);
    @(negedge clk);
    check("lat.c3", longint'(sum_abs_ed), 5);
    check("lat.err", longint'(err_cnt), 1);
    ra = '{8'd0, 8'd4, 8'd2, 8'd0};
    rb = '{8'd0, 8'd4, 8'd3, 8'd9};
    rp = '{16'd0, 16'd16, 16'd6, 16'd0};
    feed(ra, rb, rp, 1'b0, 3, "lat");
    wait_done("lat");
    check_res("lat", '{err: 1, sabs: 5, sed: 5, maxed: 5, ma: 7, mb: 7, med: 1});

    // in_valid held high throughout; a start pulse inside RUN must be ignored.
    pulse_start("hold");
    cnt = 0;
    pulsed = 1'b0;
    for (int cyc = 0; cyc < 60 && !done; cyc++) begin
      @(negedge clk);
      start    = 1'b0;
      in_valid = 1'b1;
      in_a     = 8'($urandom);
      in_b     = 8'($urandom);
      in_apprx = 16'($urandom);
      if (in_ready && cnt < 4) begin
        ra[cnt] = in_a;  rb[cnt] = in_b;  rp[cnt] = in_apprx;
        cnt++;
        if (cnt == 2 && !pulsed) begin
          start  = 1'b1;
          pulsed = 1'b1;
        end
      end else if (cnt == 4 && !done) begin
        check("hold.ready_drain", longint'(in_ready), 0);
      end
    end
    check("hold.reached_done", longint'(done), 1);
    repeat (3) begin
      @(negedge clk);
      check("hold.ready_done", longint'(in_ready), 0);
      check("hold.cnt_stable", longint'(sample_cnt), 4);
    end
    in_valid = 1'b0;
    ex = model(ra, rb, rp);
    check_res("hold", ex);

    // Randomized windows against the reference model.
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < 4; i++) begin
        int ex_p, m;
        ra[i] = 8'($urandom);
        rb[i] = 8'($urandom);
        ex_p  = int'(ra[i]) * int'(rb[i]);
        m     = int'($urandom_range(0, 3));
        if (m == 1) begin
          ex_p = ex_p + int'($urandom_range(0, 40)) - 20;
          if (ex_p < 0) ex_p = 0;
          if (ex_p > 65535) ex_p = 65535;
        end else if (m == 2) begin
          ex_p = int'($urandom_range(0, 65535));
        end
        rp[i] = 16'(ex_p);
      end
      ex = model(ra, rb, rp);
      pulse_start($sformatf("rand%0d", w));
      feed(ra, rb, rp, 1'b1, 4, $sformatf("rand%0d", w));
      wait_done($sformatf("rand%0d", w));
      check_res($sformatf("rand%0d", w), ex);
      $display("window rand%0d: err=%0d sabs=%0d sed=%0d max=%0d med=%0d", w,
               err_cnt, sum_abs_ed, $signed(sum_ed), max_ed, med);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
